// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier.
//   state_t   : multiplier control states
//   cnt_width : width of the iteration counter for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Counter must hold 0..SIZE.
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// SIZE-bit ripple-carry adder built from full_adder cells.
//   a, b : addends
//   cin  : carry into bit 0
//   sum  : SIZE-bit sum
//   cout : per-stage carry vector; cout[SIZE-1] is the overall carry out
module ripple_carry_adder #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            cin,
  output logic [SIZE-1:0] sum,
  output logic [SIZE-1:0] cout
);

  logic [SIZE-1:0] carry_in;

  assign carry_in[0] = cin;

  for (genvar i = 1; i < SIZE; i++) begin : g_chain
    assign carry_in[i] = cout[i-1];
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_in[i]),
      .sum  (sum[i]),
      .cout (cout[i])
    );
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned SIZE x SIZE shift-add multiplier, one iteration per cycle.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (a = multiplicand, b = multiplier)
//   out_valid, out_ready: product handshake
//   product             : 2*SIZE-bit a*b, valid while out_valid is high
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] product
);

  localparam int unsigned CntW = cnt_width(SIZE);

  state_t            state_q, state_d;
  logic [SIZE-1:0]   m_q, m_d;
  logic [SIZE-1:0]   acc_q, acc_d;
  logic [SIZE-1:0]   q_q, q_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [SIZE-1:0]   addend;
  logic [SIZE-1:0]   sum;
  logic [SIZE-1:0]   carry;

  assign addend = q_q[0] ? m_q : '0;

  ripple_carry_adder #(
    .SIZE (SIZE)
  ) u_adder (
    .a    (acc_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Shift {carry, sum, q} right by one; the carry is kept as ACC's MSB.
        acc_d = {carry[SIZE-1], sum[SIZE-1:1]};
        q_d   = {sum[0], q_q[SIZE-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(SIZE - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {acc_q, q_q};

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential unsigned SIZE×SIZE multiplier built around the team's `ripple_carry_adder`. It accepts one operand pair through a valid/ready handshake. Each cycle it issues one conditional add of the multiplicand into the partial-product accumulator through the adder. It returns the 2·SIZE-bit product through a second valid/ready handshake. It sits directly upstream of the adder: it generates every addend and consumes every sum and carry.

## Interface
- `SIZE`, default 4: operand width in bits; legal range ≥ 2.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low; sampled on the `clk` rising edge.
- `in_valid`, input, 1: operand pair on `a`/`b` is valid.
- `in_ready`, output, 1: block can accept an operand pair; high only in IDLE.
- `a`, input, SIZE: multiplicand, unsigned.
- `b`, input, SIZE: multiplier, unsigned.
- `out_valid`, output, 1: `product` is valid; high only in DONE.
- `out_ready`, input, 1: downstream accepts `product`.
- `product`, output, 2·SIZE: unsigned product a·b, valid while `out_valid` is high.

## Operation
- Registers:
  - M (SIZE): multiplicand.
  - ACC (SIZE): upper partial product.
  - Q (SIZE): multiplier, shifted right each iteration; it becomes the lower product half.
  - CNT: ceil(log2(SIZE+1)) bits.
  - state.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: M←a, Q←b, ACC←0, CNT←0, state←BUSY.
- BUSY, one iteration per cycle:
  - Adder inputs: A=ACC; B=(Q[0] ? M : 0); Cin=0.
  - Carry-out C = adder Cout[SIZE-1]. The adder's Cout is a per-stage carry vector; only its MSB is used.
  - Result {C, S} is shifted right one place with Q: ACC←{C, S[SIZE-1:1]}, Q←{S[0], Q[SIZE-1:1]}, CNT←CNT+1.
  - When CNT==SIZE-1 at the edge, state←DONE.
- DONE:
  - `out_valid`=1, `product`={ACC, Q}.
  - Values held stable until `out_ready`=1 at a rising edge; then state←IDLE.
- `in_valid` outside IDLE is ignored; no input is buffered.
- `out_ready` outside DONE is ignored.
- Width rule: the carry bit must never be dropped. {ACC,Q} is exact for all inputs, max (2^SIZE−1)².

## Timing
- Reset (`rst_n`=0 at an edge):
  - state←IDLE; M, ACC, Q, CNT←0.
  - Following cycle: `in_ready`=1, `out_valid`=0, `product`=0.
  - `in_ready` stays 1 while reset is held.
- Reset mid-BUSY or mid-DONE aborts the operation; no `out_valid` is produced for it.
- Latency: input accepted at edge E0; iterations at edges E1..E_SIZE; `out_valid` high from the cycle after E_SIZE. That is SIZE edges after acceptance.
- `out_valid` with `out_ready` tied high gives a one-cycle pulse.
- `in_ready` returns the cycle after the output handshake edge. Minimum issue interval is SIZE+2 cycles.
- Outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Adder path is combinational within one cycle. Critical path is the SIZE-bit ripple plus shift mux.

## Structure
- Package `mult_pkg`:
  - `state_t` enum {IDLE, BUSY, DONE}.
  - Function or localparam for CNT width: $clog2(SIZE+1).
- Sub-module: one `ripple_carry_adder #(.SIZE(SIZE))` instance for the accumulate step, which itself uses `full_adder`.
- No other hierarchy. FSM, shift registers and counter live in `shift_add_multiplier`.

## Test plan
- Reset and idle: hold `rst_n`=0 for 2 cycles, then release → `in_ready`=1, `out_valid`=0, `product`=0; no state change while `in_valid`=0.
- Basic product, SIZE=4: a=3, b=5, `out_ready`=1 → `out_valid` exactly 4 edges after acceptance for one cycle, `product`=8'h0F; `in_ready` back 1 cycle later.
- Carry path, SIZE=4: a=15, b=15 → `product`=8'hE1 (225). Also a=15, b=8 → 8'h78. Also a=0, b=15 and a=15, b=0 → 8'h00.
- Backpressure: a=7, b=9, `out_ready`=0 for 5 cycles in DONE → `out_valid` and `product`=8'h3F held stable; `in_valid` pulses with other operands during BUSY/DONE ignored; release `out_ready` → IDLE next cycle.
- Reset mid-op: accept a=12, b=13, then assert `rst_n`=0 at the 2nd BUSY edge → no `out_valid`; next operation a=2, b=2 yields 8'h04.
- Exhaustive/random at SIZE=4 and SIZE=8: back-to-back operations with random `out_ready` stalls → every product equals the a·b reference model, issue interval ≥ SIZE+2.
